// File: rtl/i2s_pkg.sv
// i2s_pkg -- definitions shared by the I2S transmitter and receiver.
//   FRAME_BCK  : bit clocks per stereo frame
//   SLOT_BCK   : bit clocks per channel slot
//   I2S_DELAY  : bit clocks between the WS edge and the sample MSB
//   i2s_pair_t : one stereo sample pair, zero-extended to MAX_DATA_W
//   slot_bit() : serial bit of a sample at a given slot position
package i2s_pkg;

   localparam int FRAME_BCK  = 64;
   localparam int SLOT_BCK   = 32;
   localparam int I2S_DELAY  = 1;
   localparam int MAX_DATA_W = 31;

   typedef struct packed {
      logic [MAX_DATA_W-1:0] left;
      logic [MAX_DATA_W-1:0] right;
   } i2s_pair_t;

   // Position k inside a slot: k=0 is the delay bit, k=1..data_w carry the
   // sample MSB first, everything after the LSB is padded with zeros.
   function automatic logic slot_bit(input logic [MAX_DATA_W-1:0] sample,
                                     input logic [4:0]            k,
                                     input int                    data_w);
      logic [4:0] idx;
      slot_bit = 1'b0;
      idx      = 5'(data_w - int'(k));
      if (int'(k) >= I2S_DELAY && int'(k) <= data_w) begin
         slot_bit = sample[idx];
      end
   endfunction

endpackage

// File: rtl/i2s_tx_2ch_bck_gen.sv
// i2s_bck_gen -- bit clock / word select timebase for the I2S transmitter.
// Ports:
//   AMCLK_i     in   audio master clock
//   ARST        in   synchronous active-high reset
//   bit_cnt     out  position in the 64-BCK frame (bit 5 = right slot)
//   fall_tick   out  high in the AMCLK cycle right after a BCK falling edge;
//                    WS and data are launched on the edge ending it
//   frame_start out  high in the AMCLK cycle whose closing edge wraps
//                    bit_cnt from 63 to 0
//   bck         out  registered bit clock
//   ws          out  registered word select (0 = left)
module i2s_bck_gen
   import i2s_pkg::*;
#(
   parameter int MCLK_PER_BCK = 8
)
(
   input  logic       AMCLK_i,
   input  logic       ARST,
   output logic [5:0] bit_cnt,
   output logic       fall_tick,
   output logic       frame_start,
   output logic       bck,
   output logic       ws
);

   localparam int               DIV_W    = $clog2(MCLK_PER_BCK);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_BCK - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_PER_BCK / 2);
   localparam logic [5:0]       BIT_LAST = 6'(FRAME_BCK - 1);

   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic [5:0]       bit_cnt_reg, bit_cnt_next;
   logic             bck_reg;
   logic             ws_reg;

   always_comb begin
      div_cnt_next = div_cnt_reg + 1'b1;
      bit_cnt_next = bit_cnt_reg;
      if (div_cnt_reg == DIV_LAST) begin
         div_cnt_next = '0;
         bit_cnt_next = bit_cnt_reg + 1'b1;   // 6-bit counter wraps 63 -> 0
      end
   end

   always_ff @(posedge AMCLK_i) begin
      if (ARST) begin
         div_cnt_reg <= '0;
         bit_cnt_reg <= BIT_LAST;
         bck_reg     <= 1'b0;
         ws_reg      <= 1'b1;
      end else begin
         div_cnt_reg <= div_cnt_next;
         bit_cnt_reg <= bit_cnt_next;
         // Registered from the next count so BCK is low exactly while the
         // divider sits in its first half; the wrap to 0 is the falling edge.
         bck_reg     <= (div_cnt_next >= DIV_HALF);
         // WS moves one AMCLK after BCK falls, together with the data bit.
         if (fall_tick) begin
            ws_reg <= bit_cnt_reg[5];
         end
      end
   end

   assign fall_tick   = (div_cnt_reg == '0);
   assign frame_start = (div_cnt_reg == DIV_LAST) && (bit_cnt_reg == BIT_LAST);
   assign bit_cnt     = bit_cnt_reg;
   assign bck         = bck_reg;
   assign ws          = ws_reg;

endmodule

// File: rtl/i2s_tx_2ch.sv
// i2s_tx_2ch -- stereo I2S transmitter, 64 BCK per frame, 32-bit slots,
// MSB one BCK after the WS edge.
// Ports:
//   AMCLK_i          in   audio master clock, all logic on its rising edge
//   ARST             in   synchronous active-high reset
//   APDATA_LEFT_i    in   left sample (signed, DATA_W bits)
//   APDATA_RIGHT_i   in   right sample (signed, DATA_W bits)
//   APDATA_VALID_i   in   one-cycle strobe qualifying the sample pair
//   downsample_2x_i  in   discard every second accepted strobe when 1
//   ASCLK_o          out  I2S bit clock
//   ALRCLK_o         out  I2S word select, 0 = left
//   ASDATA_o         out  I2S serial data
//   UNDERRUN_o       out  pulse: frame started with nothing pending
//   OVERRUN_o        out  pulse: pending pair overwritten before use
module i2s_tx_2ch
   import i2s_pkg::*;
#(
   parameter int DATA_W       = 24,
   parameter int MCLK_PER_BCK = 8
)
(
   input  logic              AMCLK_i,
   input  logic              ARST,
   input  logic [DATA_W-1:0] APDATA_LEFT_i,
   input  logic [DATA_W-1:0] APDATA_RIGHT_i,
   input  logic              APDATA_VALID_i,
   input  logic              downsample_2x_i,
   output logic              ASCLK_o,
   output logic              ALRCLK_o,
   output logic              ASDATA_o,
   output logic              UNDERRUN_o,
   output logic              OVERRUN_o
);

   logic [5:0] bit_cnt;
   logic       fall_tick;
   logic       frame_start;

   i2s_bck_gen #(
      .MCLK_PER_BCK (MCLK_PER_BCK)
   ) u_bck_gen (
      .AMCLK_i     (AMCLK_i),
      .ARST        (ARST),
      .bit_cnt     (bit_cnt),
      .fall_tick   (fall_tick),
      .frame_start (frame_start),
      .bck         (ASCLK_o),
      .ws          (ALRCLK_o)
   );

   i2s_pair_t in_pair;
   i2s_pair_t pend_reg;
   i2s_pair_t active_reg;
   logic      pend_full_reg;
   logic      ds_phase_reg;
   logic      sdata_reg;
   logic      underrun_reg;
   logic      overrun_reg;
   logic      accept;

   always_comb begin
      in_pair       = '0;
      in_pair.left  = MAX_DATA_W'(APDATA_LEFT_i);
      in_pair.right = MAX_DATA_W'(APDATA_RIGHT_i);
   end

   // While decimating, only strobes seen with ds_phase = 0 are kept.
   assign accept = APDATA_VALID_i && (!downsample_2x_i || !ds_phase_reg);

   // Serial bit for each channel at the current slot position; bit 5 of the
   // frame counter then picks the channel whose slot is on the wire.
   logic [MAX_DATA_W-1:0] chan_sample [2];
   logic [1:0]            chan_bit;
   logic                  sdata_next;

   assign chan_sample[0] = active_reg.left;
   assign chan_sample[1] = active_reg.right;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         assign chan_bit[gi] = slot_bit(chan_sample[gi], bit_cnt[4:0], DATA_W);
      end
   endgenerate

   assign sdata_next = chan_bit[bit_cnt[5]];

   always_ff @(posedge AMCLK_i) begin
      if (ARST) begin
         pend_reg      <= '0;
         active_reg    <= '0;
         pend_full_reg <= 1'b0;
         ds_phase_reg  <= 1'b0;
         sdata_reg     <= 1'b0;
         underrun_reg  <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         underrun_reg <= 1'b0;
         overrun_reg  <= 1'b0;

         if (!downsample_2x_i) begin
            ds_phase_reg <= 1'b0;
         end else if (APDATA_VALID_i) begin
            ds_phase_reg <= ~ds_phase_reg;
         end

         if (frame_start) begin
            // A pair arriving exactly at frame start bypasses the pending
            // register so it goes out in this frame without any flag.
            if (accept) begin
               active_reg    <= in_pair;
               pend_full_reg <= 1'b0;
            end else if (pend_full_reg) begin
               active_reg    <= pend_reg;
               pend_full_reg <= 1'b0;
            end else begin
               underrun_reg  <= 1'b1;         // previous pair is repeated
            end
         end else if (accept) begin
            pend_reg      <= in_pair;
            pend_full_reg <= 1'b1;
            overrun_reg   <= pend_full_reg;
         end

         if (fall_tick) begin
            sdata_reg <= sdata_next;
         end
      end
   end

   assign ASDATA_o   = sdata_reg;
   assign UNDERRUN_o = underrun_reg;
   assign OVERRUN_o  = overrun_reg;

endmodule

// File: tb/tb_i2s_tx_2ch.sv
// tb_i2s_tx_2ch -- directed scoreboard bench for i2s_tx_2ch (DATA_W=24,
// MCLK_PER_BCK=8). Stimulus pushes the pair each frame must carry; a monitor
// decodes the serial wire slot by slot and compares whole frames.
// Cycle numbering: cyc = number of rising edges since reset was released,
// so frame n starts on edge 8 + 512*n and WS falls one edge later.
module tb_i2s_tx_2ch;

   localparam int DATA_W = 24;
   localparam int M      = 8;
   localparam int FRAME  = 64 * M;

   logic              clk = 1'b0;
   logic              arst = 1'b1;
   logic [DATA_W-1:0] left_in = '0;
   logic [DATA_W-1:0] right_in = '0;
   logic              valid_in = 1'b0;
   logic              ds_in = 1'b0;
   logic              sclk, lrclk, sdata, underrun, overrun;

   always #5 clk = ~clk;

   i2s_tx_2ch #(
      .DATA_W       (DATA_W),
      .MCLK_PER_BCK (M)
   ) dut (
      .AMCLK_i         (clk),
      .ARST            (arst),
      .APDATA_LEFT_i   (left_in),
      .APDATA_RIGHT_i  (right_in),
      .APDATA_VALID_i  (valid_in),
      .downsample_2x_i (ds_in),
      .ASCLK_o         (sclk),
      .ALRCLK_o        (lrclk),
      .ASDATA_o        (sdata),
      .UNDERRUN_o      (underrun),
      .OVERRUN_o       (overrun)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ur_cnt = 0;
   int ov_cnt = 0;
   logic [63:0] exp_q [$];

   always @(posedge clk) begin
      if (arst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (underrun) ur_cnt <= ur_cnt + 1;
      if (overrun)  ov_cnt <= ov_cnt + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Slot as received MSB first: delay bit, 24 sample bits, 7 zero pad bits.
   function automatic logic [31:0] slot_word(input logic [DATA_W-1:0] s);
      slot_word = {1'b0, s, 7'b0};
   endfunction

   task automatic push_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      exp_q.push_back({slot_word(l), slot_word(r)});
   endtask

   // Returns at the falling clock edge that follows rising edge e.
   task automatic wait_cyc(input int e);
      int guard = 0;
      while (cyc < e && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // The strobe is sampled by the DUT on rising edge e.
   task automatic strobe(input int e, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      wait_cyc(e - 1);
      left_in  = l;
      right_in = r;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   function automatic int fs(input int n);
      fs = M + FRAME * n;
   endfunction

   // Monitor: samples WS/DATA at each BCK rising edge, frames start at a WS fall.
   initial begin : monitor
      logic        prev_bck, prev_ws, left_ok, right_ok;
      int          pos, fidx;
      logic [31:0] lw, rw;
      logic [63:0] e;
      prev_bck = 1'b0; prev_ws = 1'b1; left_ok = 1'b0; right_ok = 1'b0;
      pos = 0; fidx = 0; lw = '0; rw = '0;
      forever begin
         @(negedge clk);
         if (arst) begin
            prev_bck = 1'b0; prev_ws = 1'b1; left_ok = 1'b0; right_ok = 1'b0; pos = 0;
         end else begin
            if (sclk && !prev_bck) begin
               if (lrclk !== prev_ws) begin
                  pos = 0;
                  if (lrclk == 1'b0) begin
                     left_ok  = 1'b1;
                     right_ok = 1'b0;
                  end else begin
                     right_ok = left_ok;
                  end
               end else begin
                  pos++;
               end
               if (pos < 32) begin
                  if (lrclk == 1'b0) lw[31-pos] = sdata;
                  else               rw[31-pos] = sdata;
               end
               if (lrclk == 1'b1 && pos == 31 && right_ok) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL frame%0d: unexpected frame L=%h R=%h, none expected", fidx, lw, rw);
                  end else begin
                     e = exp_q.pop_front();
                     check($sformatf("frame%0d_left", fidx), 64'(lw), 64'(e[63:32]));
                     check($sformatf("frame%0d_right", fidx), 64'(rw), 64'(e[31:0]));
                  end
                  fidx++;
                  left_ok  = 1'b0;
                  right_ok = 1'b0;
               end
               prev_ws = lrclk;
            end
            prev_bck = sclk;
         end
      end
   end

   initial begin : stimulus
      int w;
      repeat (4) @(negedge clk);
      check("rst_sclk",     64'(sclk),     64'd0);
      check("rst_lrclk",    64'(lrclk),    64'd1);
      check("rst_sdata",    64'(sdata),    64'd0);
      check("rst_underrun", 64'(underrun), 64'd0);
      check("rst_overrun",  64'(overrun),  64'd0);
      arst = 1'b0;

      // Idle: frames 0 and 1 carry zeros and each raises an underrun.
      push_frame('0, '0);
      push_frame('0, '0);
      wait_cyc(8);   check("ws_at_frame_start", 64'(lrclk), 64'd1);
      wait_cyc(9);   check("ws_fall",           64'(lrclk), 64'd0);
      wait_cyc(12);  check("sclk_high",         64'(sclk),  64'd1);
      wait_cyc(16);  check("sclk_low",          64'(sclk),  64'd0);
      wait_cyc(264); check("ws_left_end",       64'(lrclk), 64'd0);
      wait_cyc(265); check("ws_rise_right",     64'(lrclk), 64'd1);
      wait_cyc(600); check("underrun_idle",     64'(ur_cnt), 64'd2);

      // Single pair, sent in frame 2 and repeated in frame 3 (underrun).
      strobe(700, 24'h800001, 24'h7FFFFE);
      push_frame(24'h800001, 24'h7FFFFE);
      push_frame(24'h800001, 24'h7FFFFE);

      // One strobe per frame for frames 4..6.
      for (int i = 0; i < 3; i++) begin
         strobe(fs(3 + i) + 100, 24'h000100 + 24'(i), 24'hABC000 + 24'(i));
         push_frame(24'h000100 + 24'(i), 24'hABC000 + 24'(i));
      end
      wait_cyc(fs(6) + 50);
      check("underrun_after_stream", 64'(ur_cnt), 64'd3);
      check("overrun_after_stream",  64'(ov_cnt), 64'd0);

      // Decimation: values 1..6 at twice the frame rate, odd ones kept.
      ds_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         strobe(fs(6 + i) + 100, 24'(2 * i + 1), 24'h800000 | 24'(2 * i + 1));
         strobe(fs(6 + i) + 356, 24'(2 * i + 2), 24'h800000 | 24'(2 * i + 2));
         push_frame(24'(2 * i + 1), 24'h800000 | 24'(2 * i + 1));
      end
      ds_in = 1'b0;
      wait_cyc(fs(9) + 50);
      check("overrun_decimate",  64'(ov_cnt), 64'd0);
      check("underrun_decimate", 64'(ur_cnt), 64'd3);

      // Two strobes in one frame: only the second is sent.
      strobe(fs(9) + 100, 24'h111111, 24'h222222);
      strobe(fs(9) + 200, 24'h333333, 24'h444444);
      push_frame(24'h333333, 24'h444444);
      wait_cyc(fs(9) + 250);
      check("overrun_once", 64'(ov_cnt), 64'd1);

      // Strobe on the frame-start cycle goes straight into frame 11.
      strobe(fs(11), 24'h5A5A5A, 24'hA5A5A5);
      push_frame(24'h5A5A5A, 24'hA5A5A5);
      wait_cyc(fs(11) + 50);
      check("underrun_simul", 64'(ur_cnt), 64'd3);
      check("overrun_simul",  64'(ov_cnt), 64'd1);

      // Reset for three cycles in the right slot of frame 12 (not completed).
      wait_cyc(fs(12) + 299);
      check("queue_before_reset", 64'(exp_q.size()), 64'd0);
      check("underrun_frame12",   64'(ur_cnt), 64'd4);
      arst = 1'b1;
      repeat (3) @(negedge clk);
      check("rel_sclk",     64'(sclk),     64'd0);
      check("rel_lrclk",    64'(lrclk),    64'd1);
      check("rel_sdata",    64'(sdata),    64'd0);
      check("rel_underrun", 64'(underrun), 64'd0);
      check("rel_overrun",  64'(overrun),  64'd0);
      arst = 1'b0;
      push_frame('0, '0);
      wait_cyc(8);   check("ws_after_reset",      64'(lrclk), 64'd1);
      wait_cyc(9);   check("ws_fall_after_reset", 64'(lrclk), 64'd0);
      wait_cyc(100); check("underrun_after_reset", 64'(ur_cnt), 64'd5);

      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("frames_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
